// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file package: default address/data widths and a
// constant-foldable ceil(log2) helper. MultiReg instantiation sites can
// import it as well.
package rf_pkg;

    localparam int ADDR_WIDTH = 3;
    localparam int DATA_WIDTH = 8;

    // Smallest w such that 2**w >= value; used to size grant indices.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker. The request vector is rotated so that
// index ptr_i sits at bit 0, the lowest set bit is found, and that position
// is rotated back into a one-hot grant and an absolute index.
module rr_pick #(
    parameter int n_req    = 4,
    parameter int id_width = 2
) (
    input  logic [n_req-1:0]    req_i,
    input  logic [id_width-1:0] ptr_i,
    output logic [n_req-1:0]    grant_o,
    output logic [id_width-1:0] grant_idx_o,
    output logic                any_o
);

    localparam logic [id_width:0] N_EXT = (id_width + 1)'(n_req);

    // (a + b) mod n_req, assuming both operands are already below n_req.
    function automatic logic [id_width-1:0] wrap_add(input logic [id_width-1:0] a,
                                                     input logic [id_width-1:0] b);
        logic [id_width:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= N_EXT) begin
            s = s - N_EXT;
        end
        return s[id_width-1:0];
    endfunction

    logic [n_req-1:0]    rot;
    logic [id_width-1:0] first_idx;
    logic                found;

    // Rotate so that the highest-priority requester lands on bit 0.
    for (genvar gi = 0; gi < n_req; gi++) begin : g_rot
        assign rot[gi] = req_i[wrap_add(id_width'(gi), ptr_i)];
    end

    // Priority-encode the rotated vector: lowest set bit wins.
    always_comb begin
        found     = 1'b0;
        first_idx = '0;
        for (int j = 0; j < n_req; j++) begin
            if (!found && rot[j]) begin
                found     = 1'b1;
                first_idx = id_width'(j);
            end
        end
    end

    assign any_o       = found;
    assign grant_idx_o = wrap_add(first_idx, ptr_i);
    assign grant_o     = found ? (n_req'(1) << grant_idx_o) : '0;

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// n_req requesters. One grant per cycle; the accepted write is presented
// on registered wr_* outputs during the following cycle.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int n_req      = 4,
    parameter int addr_width = ADDR_WIDTH,
    parameter int data_width = DATA_WIDTH,
    parameter int id_width   = clog2(n_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [n_req-1:0]              req_valid,
    input  logic [n_req*addr_width-1:0]   req_addr,
    input  logic [n_req*data_width-1:0]   req_data,
    output logic [n_req-1:0]              req_ready,
    output logic                          wr_en,
    output logic [addr_width-1:0]         wr_addr,
    output logic [data_width-1:0]         wr_data,
    output logic [id_width-1:0]           grant_id
);

    logic [id_width-1:0]   ptr_q, ptr_d;
    logic                  wr_en_q, wr_en_d;
    logic [addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [data_width-1:0] wr_data_q, wr_data_d;
    logic [id_width-1:0]   grant_id_q, grant_id_d;

    logic [n_req-1:0]      pick_grant;
    logic [id_width-1:0]   pick_idx;
    logic                  pick_any;
    logic                  xfer;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;

    rr_pick #(
        .n_req    (n_req),
        .id_width (id_width)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_o       (pick_any)
    );

    // Grants depend only on valid, en and ptr; held off while in reset.
    assign req_ready = (en && rst) ? pick_grant : '0;
    assign xfer      = en & rst & pick_any;

    // One-hot slice mux selecting the granted requester's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < n_req; i++) begin
            if (pick_grant[i]) begin
                sel_addr = req_addr[i*addr_width +: addr_width];
                sel_data = req_data[i*data_width +: data_width];
            end
        end
    end

    // Next state: capture the winner and move priority just past it.
    always_comb begin
        ptr_d      = ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (xfer) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            grant_id_d = pick_idx;
            ptr_d      = (pick_idx == id_width'(n_req - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule
